// File: rtl/timer_responder_if.sv
// Bus bundle between the CPU data-side bridge and the timer.
// master drives req/we/addr/be/wdata; slave returns ready/rdata/irq.
interface timer_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rdata, irq
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rdata, irq
  );
endinterface

// File: rtl/timer_responder.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT and maskable irq.
// Ports: clk, reset (async, active-low), bus (timer_responder_if.slave).
module timer_responder #(
  parameter int CNT_W = 32
) (
  input logic              clk,
  input logic              reset,
  timer_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;
  logic             ready_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rd_mux;
  logic [31:0]      pre_mrg;

  logic       wr;
  logic       wr_ctrl;
  logic       wr_ctrl_b0;
  logic       wr_pre;
  logic [3:0] ctrl_eff;
  logic       en_eff;
  logic       reload;
  logic       cnt_zero;

  logic cnt_load;
  logic cnt_dec;
  logic flag_set;
  logic en_clr;

  assign wr         = bus.req & bus.we;
  assign wr_ctrl    = wr & (bus.addr == 2'd0);
  assign wr_ctrl_b0 = wr_ctrl & bus.be[0];
  assign wr_pre     = wr & (bus.addr == 2'd1);

  // A CTRL store is seen by the control logic in the cycle it is
  // issued, so the FSM reacts to EN one cycle earlier and a store
  // always overrides the FSM clearing EN.
  assign ctrl_eff = wr_ctrl_b0 ? bus.wdata[3:0] : ctrl;
  assign en_eff   = ctrl_eff[0];
  assign reload   = (ctrl_eff[2:1] == 2'b01);
  assign cnt_zero = (count == '0);

  always_comb begin
    pre_mrg = 32'(preset);
    for (int i = 0; i < 4; i++) begin
      if (bus.be[i]) pre_mrg[8*i +: 8] = bus.wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (en_eff) state_nx = LOAD;
      LOAD: state_nx = CNT;
      CNT: begin
        if (!en_eff)       state_nx = IDLE;
        else if (cnt_zero) state_nx = INT;
      end
      INT: state_nx = reload ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    flag_set = 1'b0;
    en_clr   = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: cnt_load = 1'b1;
      CNT:  cnt_dec  = en_eff & ~cnt_zero;
      INT: begin
        flag_set = 1'b1;
        en_clr   = ~reload;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.addr)
      2'd0:    rd_mux = {28'd0, ctrl};
      2'd1:    rd_mux = 32'(preset);
      2'd2:    rd_mux = 32'(count);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (wr_ctrl_b0)  ctrl    <= bus.wdata[3:0];
      else if (en_clr) ctrl[0] <= 1'b0;

      if (wr_pre) preset <= pre_mrg[CNT_W-1:0];

      if (cnt_load)     count <= preset;
      else if (cnt_dec) count <= count - CNT_W'(1);

      // The set has priority so an interrupt is never lost.
      if (flag_set)                   irq_flag <= 1'b1;
      else if (wr_ctrl && bus.be != 0) irq_flag <= 1'b0;

      ready_q <= bus.req;
      rdata_q <= (bus.req & ~bus.we) ? rd_mux : '0;
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_flag & ctrl_eff[3];

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
- Memory-mapped timer/counter peripheral that responds to load/store requests from the pipelined MIPS CPU's data-side bus, driven through the bridge's device select.
- Holds three word registers: CTRL, PRESET and COUNT.
- Counts down from PRESET and raises a maskable interrupt request back to the CPU.
- Single clock domain. Acts purely as a bus responder; it never initiates a transfer.

Parameters:
- CNT_W, 32: width of PRESET and COUNT. Must be ≤32. Reads zero-extend to 32 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- req  in  1  access request from the bridge, valid for one cycle.
- we  in  1  1 = store, 0 = load. Qualified by req.
- addr  in  2  word offset: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped.
- be  in  4  byte enables for stores. Bit i enables wdata[8i+7:8i].
- wdata  in  32  store data.
- ready  out  1  registered one-cycle pulse acknowledging the previous cycle's req.
- rdata  out  32  load data. Valid while ready=1; 0 otherwise.
- irq  out  1  interrupt request = irq_flag & CTRL.IM.

Behaviour:
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Outputs: ready=0, rdata=0, irq=0.
- CTRL bit fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot.
  - [3] IM: interrupt mask (1 = irq enabled).
  - [31:4] are reserved: ignored on write, read as 0.
- Handshake:
  - req=1 in cycle N produces ready=1 in cycle N+1.
  - For loads, rdata in N+1 is the register value sampled at the clock edge ending cycle N, i.e. the pre-write value.
  - Back-to-back requests are accepted every cycle. No wait states. ready never stalls.
- Stores (req & we) update the target register at the end of cycle N, byte-lane merged per be:
  - COUNT is read-only; stores to it are ignored.
  - Stores to addr 3 are ignored.
  - Loads from addr 3 return 0.
  - Any store to CTRL (any be≠0) also clears irq_flag.
- State machine (advances every cycle):
  - IDLE: if EN=1, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT <= PRESET. Go to CNT.
  - CNT:
    - If EN=0, go to IDLE; COUNT holds its value.
    - Else if COUNT==0, go to INT.
    - Else COUNT <= COUNT-1 and stay in CNT.
  - INT: irq_flag <= 1.
    - If MODE==01, go to LOAD.
    - Else clear CTRL.EN and go to IDLE.
- Timing: with PRESET=P≥1 and EN set by a store in cycle N:
  - LOAD in N+1, COUNT=P in N+2, COUNT=0 in N+2+P.
  - INT in N+3+P; irq visible in N+4+P.
  - PRESET=0 behaves as P=0: INT in N+3.
- Simultaneous events:
  - A CPU store to CTRL in the same cycle the FSM clears EN in INT: the store wins.
  - A store writing EN=0 during CNT: the FSM reaches IDLE one cycle later; at most one more decrement may occur in that cycle.
  - A CTRL store coinciding with INT setting irq_flag: the set wins, so no interrupt is lost.
  - A store to PRESET during CNT does not disturb the running count; it takes effect at the next LOAD.
- Arithmetic: COUNT is unsigned CNT_W bits. It never underflows, because the decrement is blocked at 0.
- Reset mid-operation: all state returns to reset values asynchronously. Any ready pulse in flight is dropped.

Test Plan:
- Reset/readback: release reset; load addr 0, 1, 2 -> ready one cycle after each req, rdata=0 each. Store 0xFFFF_FFFF to CTRL -> readback 0x0000_000F.
- One-shot: PRESET=5, CTRL=0x9 (EN, IM, one-shot) stored at cycle N -> COUNT sequence 5,4,3,2,1,0. irq=1 at N+9. Readback of CTRL = 0x8. irq stays 1 until any CTRL store, then falls the next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> irq_flag first set at N+6. COUNT reloads to 2 and the period repeats every 5 cycles (LOAD, 2, 1, 0, INT).
- Masking: CTRL=0x1 with PRESET=3 -> irq stays 0 throughout; irq_flag=1 internally. A store of CTRL=0x8 then raises irq, and that same store clears irq_flag, so irq returns to 0 one cycle later.
- Byte enables and unmapped: store 0x1234_5678 to PRESET with be=0b0011 over PRESET=0xAAAA_AAAA -> readback 0xAAAA_5678. Store to COUNT or addr 3 -> no change. Load addr 3 -> 0.
- Disable and reset mid-count: PRESET=100; store CTRL=0 during CNT -> COUNT freezes within one cycle and the FSM is in IDLE. Restart, then pull reset low mid-count -> COUNT, CTRL, irq, ready all 0 immediately, without waiting for a clk edge.
